// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
// Stream bundle between the program-loader front end, the instruction
// encoder and instruction memory.
//   in_valid/in_ready   descriptor handshake (front end -> encoder)
//   in_op/rd/rn/rm/imm  decoded instruction descriptor
//   out_valid/out_ready machine-word handshake (encoder -> memory)
//   out_instr/out_addr  encoded 32-bit word and its byte address
//   err                 sticky encode error flag
// master: the side producing descriptors and consuming words.
// slave : the encoder itself.
// ADDR_W must match the ADDR_W of the attached instr_encoder.
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [25:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err
    );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Turns decoded LEGv8 descriptors (ADDI, ADDS, AND, B, B.LT, CBZ, EOR, LDUR,
// LSR, STUR, SUBS) into 32-bit machine words, streamed out with a running
// byte address. Every B / B.LT / CBZ is followed by DELAY_SLOTS NOP words
// (ADDI X31,X31,#0) to fill the pipeline's branch delay slot.
//
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    instr_encoder_if.slave (descriptor in, word/address out, err)
//
// Parameters:
//   ADDR_W       width of out_addr
//   BASE_ADDR    byte address of the first word after reset (multiple of 4)
//   DELAY_SLOTS  NOPs inserted after each branch, 0..3
//
// Optional feature, macro ENC_RANGE_CHECK_EN:
//   defined   -> out-of-range immediates and illegal ops (11..15) are
//                accepted but dropped and err is set until reset
//   undefined -> immediates truncate to field width, illegal ops emit a
//                NOP and err is tied to 0
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 0,
    parameter int DELAY_SLOTS = 1
) (
    input  logic             clk,
    input  logic             reset,
    instr_encoder_if.slave   bus
);
    localparam logic [31:0] NOP = 32'h910003FF;

    typedef enum logic {RUN, PAD} state_t;

    state_t            state, state_n;
    logic [1:0]        pad_cnt, pad_cnt_n;
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_addr_q;

    logic              in_ready;
    logic              accept;
    logic              consume;
    logic              load;
    logic [31:0]       load_word;
    logic [31:0]       enc_word;
    logic              is_branch;
    logic              drop;

    // The output register can take a new word when empty or being drained.
    assign in_ready = (state == RUN) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = out_valid_q && bus.out_ready;

    // Field packing for each op; illegal ops fall through to a NOP.
    always_comb begin
        enc_word  = NOP;
        is_branch = 1'b0;
        case (bus.in_op)
            4'd0:  enc_word = {10'b1001000100, bus.in_imm[11:0], bus.in_rn, bus.in_rd};
            4'd1:  enc_word = {11'b10101011000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
            4'd2:  enc_word = {11'b10001010000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
            4'd3:  begin
                enc_word  = {6'b000101, bus.in_imm};
                is_branch = 1'b1;
            end
            4'd4:  begin
                enc_word  = {8'b01010100, bus.in_imm[18:0], 5'b01011};
                is_branch = 1'b1;
            end
            4'd5:  begin
                enc_word  = {8'b10110100, bus.in_imm[18:0], bus.in_rd};
                is_branch = 1'b1;
            end
            4'd6:  enc_word = {11'b11001010000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
            4'd7:  enc_word = {11'b11111000010, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
            4'd8:  enc_word = {11'b11010011010, 5'b0, bus.in_imm[5:0], bus.in_rn, bus.in_rd};
            4'd9:  enc_word = {11'b11111000000, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
            4'd10: enc_word = {11'b11101011000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
            default: enc_word = NOP;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic range_err;
    logic err_q;

    // Signed fields are in range when every bit above the field's sign bit
    // repeats it; unsigned fields need all bits above the field to be zero.
    always_comb begin
        range_err = 1'b0;
        case (bus.in_op)
            4'd0:       range_err = |bus.in_imm[25:12];
            4'd8:       range_err = |bus.in_imm[25:6];
            4'd7, 4'd9: range_err = !((&bus.in_imm[25:8]) || !(|bus.in_imm[25:8]));
            4'd4, 4'd5: range_err = !((&bus.in_imm[25:18]) || !(|bus.in_imm[25:18]));
            4'd1, 4'd2, 4'd3, 4'd6, 4'd10: range_err = 1'b0;
            default:    range_err = 1'b1;
        endcase
    end

    assign drop = range_err;

    // Sticky error: once a descriptor is dropped it stays set until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept && range_err) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign drop    = 1'b0;
    assign bus.err = 1'b0;
`endif

    // Next-state logic: RUN loads accepted descriptors, PAD feeds NOPs
    // into the output register whenever it has room.
    always_comb begin
        state_n   = state;
        pad_cnt_n = pad_cnt;
        load      = 1'b0;
        load_word = NOP;
        case (state)
            RUN: begin
                if (accept && !drop) begin
                    load      = 1'b1;
                    load_word = enc_word;
                    if (is_branch && (DELAY_SLOTS > 0)) begin
                        pad_cnt_n = 2'(DELAY_SLOTS);
                        state_n   = PAD;
                    end
                end
            end
            PAD: begin
                if (!out_valid_q || bus.out_ready) begin
                    load      = 1'b1;
                    load_word = NOP;
                    pad_cnt_n = pad_cnt - 2'd1;
                    if (pad_cnt == 2'd1) begin
                        state_n = RUN;
                    end
                end
            end
            default: begin
                state_n   = RUN;
                pad_cnt_n = 2'd0;
            end
        endcase
    end

    // State register plus output stage; the address advances only when a
    // word leaves, so it always names the word currently presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pad_cnt     <= 2'd0;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP;
            out_addr_q  <= ADDR_W'(BASE_ADDR);
        end else begin
            state   <= state_n;
            pad_cnt <= pad_cnt_n;
            if (consume) begin
                out_addr_q <= out_addr_q + ADDR_W'(4);
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_instr_q <= load_word;
            end else if (consume) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
endmodule
